// File: rtl/mips_isa_pkg.sv
// rtl/mips_isa_pkg.sv - opcodes, instruction types and expected control bits for the encoder ISA
package mips_isa_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_ADDI = 4'b0010;
  localparam logic [3:0] OP_LW   = 4'b0011;
  localparam logic [3:0] OP_SW   = 4'b0100;
  localparam logic [3:0] OP_J    = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;

  typedef enum logic [1:0] {
    ITYPE_R,
    ITYPE_I,
    ITYPE_J,
    ITYPE_BAD
  } instr_type_e;

  typedef struct packed {
    logic regdst;
    logic alusrc;
    logic memtoreg;
    logic memwrite;
    logic memread;
    logic regwrite;
    logic jump;
  } ctl_t;

  function automatic instr_type_e op_type(input logic [3:0] op);
    instr_type_e t;
    case (op)
      OP_ADD, OP_SUB, OP_XOR, OP_OR: t = ITYPE_R;
      OP_ADDI, OP_LW, OP_SW:         t = ITYPE_I;
      OP_J:                          t = ITYPE_J;
      default:                       t = ITYPE_BAD;
    endcase
    return t;
  endfunction

  // Decode table: the only control bundle considered legal for each opcode.
  function automatic ctl_t expected_ctl(input logic [3:0] op);
    ctl_t c;
    c = '0;
    case (op)
      OP_ADD, OP_SUB, OP_XOR, OP_OR: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      OP_ADDI: begin
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
      end
      OP_LW: begin
        c.alusrc   = 1'b1;
        c.memtoreg = 1'b1;
        c.memread  = 1'b1;
        c.regwrite = 1'b1;
      end
      OP_SW: begin
        c.alusrc   = 1'b1;
        c.memwrite = 1'b1;
      end
      OP_J: c.jump = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with synchronous clear and occupancy count
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: empty hides stale contents from the reader.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes control bundles into 16-bit words and streams them to instruction memory; INSTR_ENC_CHECK_EN enables bundle legality checking
module instr_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          ctl_regdst,
  input  logic                          ctl_alusrc,
  input  logic                          ctl_memtoreg,
  input  logic                          ctl_memwrite,
  input  logic                          ctl_memread,
  input  logic                          ctl_regwrite,
  input  logic                          ctl_jump,
  input  logic [3:0]                    ctl_aluop,
  input  logic [3:0]                    f_rs,
  input  logic [3:0]                    f_rt,
  input  logic [3:0]                    f_rd,
  input  logic [11:0]                   j_addr,
  input  logic                          flush,
  output logic                          imem_we,
  input  logic                          imem_ready,
  output logic [ADDR_W-1:0]             imem_addr,
  output logic [15:0]                   imem_wdata,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          err
);

  import mips_isa_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        op;
  instr_type_e       itype;
  logic [15:0]       word;
  logic [15:0]       head;
  logic              legal, accept, push, pop, illegal;
  logic              full, empty;

  assign op    = ctl_jump ? OP_J : ctl_aluop;
  assign itype = op_type(op);

  always_comb begin
    word = 16'h0000;
    case (itype)
      ITYPE_J: word = {OP_J, j_addr};
      default: word = {op, f_rs, f_rt, f_rd};
    endcase
  end

`ifdef INSTR_ENC_CHECK_EN
  ctl_t ctl_in;
  logic err_q, err_d;

  assign ctl_in = '{regdst:   ctl_regdst,
                    alusrc:   ctl_alusrc,
                    memtoreg: ctl_memtoreg,
                    memwrite: ctl_memwrite,
                    memread:  ctl_memread,
                    regwrite: ctl_regwrite,
                    jump:     ctl_jump};
  assign legal  = (itype != ITYPE_BAD) && (ctl_in == expected_ctl(op));

  always_comb begin
    err_d = err_q;
    if (flush)        err_d = 1'b0;
    else if (illegal) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_ctl;

  assign unused_ctl = ^{ctl_regdst, ctl_alusrc, ctl_memtoreg, ctl_memwrite,
                        ctl_memread, ctl_regwrite};
  assign legal      = 1'b1;
  assign err        = 1'b0;
`endif

  // Gating with rst_n keeps in_ready low for the whole reset assertion.
  assign in_ready = rst_n && !full && (state_q != S_ERR) && !flush;
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal;
  assign illegal  = accept && !legal;
  assign pop      = imem_we && imem_ready && !flush;

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata (word),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign imem_we    = !empty;
  assign imem_wdata = empty ? 16'h0000 : head;
  assign imem_addr  = addr_q;

  always_comb begin
    addr_d = addr_q;
    if (flush)    addr_d = '0;
    else if (pop) addr_d = addr_q + ADDR_W'(1);
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else if (illegal) begin
      state_d = S_ERR;
    end else begin
      case (state_q)
        S_IDLE:  if (push) state_d = S_WRITE;
        S_WRITE: if (pop && !push && count == CW'(1)) state_d = S_IDLE;
        S_ERR:   state_d = S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        ctl_regdst, ctl_alusrc, ctl_memtoreg, ctl_memwrite;
  logic        ctl_memread, ctl_regwrite, ctl_jump;
  logic [3:0]  ctl_aluop, f_rs, f_rt, f_rd;
  logic [11:0] j_addr;
  logic        flush;
  logic        imem_we;
  logic        imem_ready;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic [2:0]  count;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_encoder #(.FIFO_DEPTH(4), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ctl_regdst(ctl_regdst), .ctl_alusrc(ctl_alusrc), .ctl_memtoreg(ctl_memtoreg),
    .ctl_memwrite(ctl_memwrite), .ctl_memread(ctl_memread), .ctl_regwrite(ctl_regwrite),
    .ctl_jump(ctl_jump), .ctl_aluop(ctl_aluop), .f_rs(f_rs), .f_rt(f_rt), .f_rd(f_rd),
    .j_addr(j_addr), .flush(flush), .imem_we(imem_we), .imem_ready(imem_ready),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .count(count), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                            input logic [3:0] rd, input logic [11:0] ja);
    {ctl_regdst, ctl_alusrc, ctl_memtoreg, ctl_memwrite, ctl_memread, ctl_regwrite, ctl_jump} = 7'b0;
    ctl_aluop = op; f_rs = rs; f_rt = rt; f_rd = rd; j_addr = ja;
    case (op)
      4'h0, 4'h1, 4'h6, 4'h7: begin ctl_regdst = 1'b1; ctl_regwrite = 1'b1; end
      4'h2: begin ctl_alusrc = 1'b1; ctl_regwrite = 1'b1; end
      4'h3: begin ctl_alusrc = 1'b1; ctl_memtoreg = 1'b1; ctl_memread = 1'b1; ctl_regwrite = 1'b1; end
      4'h4: begin ctl_alusrc = 1'b1; ctl_memwrite = 1'b1; end
      4'h5: begin ctl_jump = 1'b1; ctl_aluop = 4'h0; end
      default: ;
    endcase
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; imem_ready = 1'b0;
    set_bundle(4'h0, 4'h0, 4'h0, 4'h0, 12'h000);
    #3;
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", imem_we); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL rst_addr got=%h exp=00", imem_addr); end
    total++; if (imem_wdata !== 16'h0000) begin bad++; $display("FAIL rst_wdata got=%h exp=0000", imem_wdata); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", in_ready); end
    step();
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add();
    set_bundle(4'h0, 4'h1, 4'h2, 4'h3, 12'h000);
    in_valid = 1'b1; imem_ready = 1'b0;
    step();
    in_valid = 1'b0;
    #1;
    total++; if (imem_we !== 1'b1) begin bad++; $display("FAIL add_we got=%b exp=1", imem_we); end
    total++; if (imem_wdata !== 16'h0123) begin bad++; $display("FAIL add_wdata got=%h exp=0123", imem_wdata); end
    total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL add_addr got=%h exp=00", imem_addr); end
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    #1;
    total++; if (imem_addr !== 8'h01) begin bad++; $display("FAIL add_addr_after got=%h exp=01", imem_addr); end
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL add_we_after got=%b exp=0", imem_we); end
  endtask

  task automatic test_jump_stall();
    do_flush();
    set_bundle(4'h5, 4'h0, 4'h0, 4'h0, 12'hABC);
    in_valid = 1'b1; imem_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (imem_we !== 1'b1 || imem_wdata !== 16'h5ABC || imem_addr !== 8'h00) begin
        bad++; $display("FAIL j_hold[%0d] got we=%b wdata=%h addr=%h exp we=1 wdata=5abc addr=00", i, imem_we, imem_wdata, imem_addr);
      end
      step();
    end
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    #1;
    total++; if (imem_addr !== 8'h01) begin bad++; $display("FAIL j_addr got=%h exp=01", imem_addr); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL j_count got=%0d exp=0", count); end
  endtask

  task automatic test_full();
    logic [15:0] exp_w [4];
    exp_w[0] = 16'h1456; exp_w[1] = 16'h6789; exp_w[2] = 16'h7ABC; exp_w[3] = 16'h312F;
    do_flush();
    imem_ready = 1'b0;
    in_valid = 1'b1;
    set_bundle(4'h1, 4'h4, 4'h5, 4'h6, 12'h000); step();
    set_bundle(4'h6, 4'h7, 4'h8, 4'h9, 12'h000); step();
    set_bundle(4'h7, 4'hA, 4'hB, 4'hC, 12'h000); step();
    set_bundle(4'h3, 4'h1, 4'h2, 4'hF, 12'h000); step();
    set_bundle(4'h2, 4'h2, 4'h3, 4'h4, 12'h000);
    #1;
    total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", in_ready); end
    step();
    #1;
    total++; if (count !== 3'd4) begin bad++; $display("FAIL full_fifth got=%0d exp=4", count); end
    imem_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_pop_ready got=%b exp=0", in_ready); end
    for (int i = 0; i < 4; i++) begin
      total++; if (imem_wdata !== exp_w[i] || imem_addr !== 8'(i)) begin
        bad++; $display("FAIL full_order[%0d] got wdata=%h addr=%h exp wdata=%h addr=%h", i, imem_wdata, imem_addr, exp_w[i], 8'(i));
      end
      step();
      in_valid = 1'b0;
      #1;
    end
    imem_ready = 1'b0;
    total++; if (count !== 3'd0 || imem_addr !== 8'h04) begin
      bad++; $display("FAIL full_drain got count=%0d addr=%h exp count=0 addr=04", count, imem_addr);
    end
  endtask

  task automatic test_back_to_back();
    do_flush();
    imem_ready = 1'b0;
    in_valid = 1'b1;
    set_bundle(4'h0, 4'h1, 4'h1, 4'h1, 12'h000); step();
    set_bundle(4'h1, 4'h2, 4'h2, 4'h2, 12'h000); step();
    set_bundle(4'h6, 4'h3, 4'h3, 4'h3, 12'h000);
    imem_ready = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    total++; if (count !== 3'd2 || imem_wdata !== 16'h1222) begin
      bad++; $display("FAIL b2b_mid got count=%0d wdata=%h exp count=2 wdata=1222", count, imem_wdata);
    end
    step();
    total++; if (imem_wdata !== 16'h6333) begin bad++; $display("FAIL b2b_last got=%h exp=6333", imem_wdata); end
    step();
    imem_ready = 1'b0;
    total++; if (count !== 3'd0 || imem_addr !== 8'h03) begin
      bad++; $display("FAIL b2b_end got count=%0d addr=%h exp count=0 addr=03", count, imem_addr);
    end
  endtask

  task automatic test_wrap();
    int budget;
    do_flush();
    imem_ready = 1'b1;
    set_bundle(4'h0, 4'h0, 4'h0, 4'h0, 12'h000);
    in_valid = 1'b1;
    for (int i = 0; i < 255; i++) step();
    in_valid = 1'b0;
    budget = 0;
    while (count !== 3'd0 && budget < 10) begin step(); budget++; end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL wrap_drain_timeout got=%0d exp=0", count); end
    total++; if (imem_addr !== 8'hFF) begin bad++; $display("FAIL wrap_pre got=%h exp=ff", imem_addr); end
    imem_ready = 1'b0;
    in_valid = 1'b1;
    set_bundle(4'h0, 4'h1, 4'h2, 4'h3, 12'h000); step();
    set_bundle(4'h1, 4'h4, 4'h5, 4'h6, 12'h000); step();
    in_valid = 1'b0;
    #1;
    total++; if (imem_addr !== 8'hFF || imem_wdata !== 16'h0123) begin
      bad++; $display("FAIL wrap_first got addr=%h wdata=%h exp addr=ff wdata=0123", imem_addr, imem_wdata);
    end
    imem_ready = 1'b1;
    step();
    total++; if (imem_addr !== 8'h00 || imem_wdata !== 16'h1456) begin
      bad++; $display("FAIL wrap_second got addr=%h wdata=%h exp addr=00 wdata=1456", imem_addr, imem_wdata);
    end
    step();
    imem_ready = 1'b0;
    total++; if (imem_addr !== 8'h01 || count !== 3'd0) begin
      bad++; $display("FAIL wrap_end got addr=%h count=%0d exp addr=01 count=0", imem_addr, count);
    end
  endtask

  task automatic test_illegal();
    do_flush();
    imem_ready = 1'b0;
`ifdef INSTR_ENC_CHECK_EN
    set_bundle(4'h0, 4'h1, 4'h2, 4'h3, 12'h000);
    in_valid = 1'b1;
    step();
    set_bundle(4'h2, 4'h1, 4'h2, 4'h3, 12'h000);
    ctl_memread = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ill_ready_pre got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL ill_err got=%b exp=1", err); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ill_ready got=%b exp=0", in_ready); end
    total++; if (count !== 3'd1 || imem_wdata !== 16'h0123) begin
      bad++; $display("FAIL ill_not_pushed got count=%0d wdata=%h exp count=1 wdata=0123", count, imem_wdata);
    end
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    total++; if (count !== 3'd0 || imem_addr !== 8'h01 || in_ready !== 1'b0) begin
      bad++; $display("FAIL ill_drain got count=%0d addr=%h ready=%b exp count=0 addr=01 ready=0", count, imem_addr, in_ready);
    end
    do_flush();
    #1;
    total++; if (err !== 1'b0 || in_ready !== 1'b1 || imem_addr !== 8'h00) begin
      bad++; $display("FAIL ill_flush got err=%b ready=%b addr=%h exp err=0 ready=1 addr=00", err, in_ready, imem_addr);
    end
`else
    set_bundle(4'h2, 4'h1, 4'h2, 4'h3, 12'h000);
    ctl_memread = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    total++; if (err !== 1'b0 || count !== 3'd1 || imem_wdata !== 16'h2123) begin
      bad++; $display("FAIL nochk_push got err=%b count=%0d wdata=%h exp err=0 count=1 wdata=2123", err, count, imem_wdata);
    end
    do_flush();
    #1;
    total++; if (count !== 3'd0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL nochk_flush got count=%0d ready=%b exp count=0 ready=1", count, in_ready);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_flush();
    imem_ready = 1'b0;
    in_valid = 1'b1;
    set_bundle(4'h0, 4'h1, 4'h2, 4'h3, 12'h000); step();
    set_bundle(4'h1, 4'h1, 4'h2, 4'h3, 12'h000); step();
    in_valid = 1'b0;
    #1;
    total++; if (count !== 3'd2 || imem_we !== 1'b1) begin
      bad++; $display("FAIL rmid_pre got count=%0d we=%b exp count=2 we=1", count, imem_we);
    end
    rst_n = 1'b0;
    #1;
    total++; if (imem_we !== 1'b0 || count !== 3'd0 || in_ready !== 1'b0 || imem_wdata !== 16'h0000) begin
      bad++; $display("FAIL rmid_async got we=%b count=%0d ready=%b wdata=%h exp we=0 count=0 ready=0 wdata=0000", imem_we, count, in_ready, imem_wdata);
    end
    step();
    rst_n = 1'b1;
    step();
    total++; if (in_ready !== 1'b1 || count !== 3'd0 || imem_we !== 1'b0) begin
      bad++; $display("FAIL rmid_after got ready=%b count=%0d we=%b exp ready=1 count=0 we=0", in_ready, count, imem_we);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_jump_stall();
    test_full();
    test_back_to_back();
    test_wrap();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sets the number of encoded words buffered (power of two, 2..16).
REQ-002 Parameter ADDR_W, default 8, sets the instruction-memory address width.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  control bundle and fields are valid.
- in_ready  out  1  block accepts the bundle this cycle.
- ctl_regdst, ctl_alusrc, ctl_memtoreg, ctl_memwrite, ctl_memread, ctl_regwrite, ctl_jump  in  1 each  control bundle.
- ctl_aluop  in  4  ALU operation code.
- f_rs, f_rt  in  4 each  source register fields.
- f_rd  in  4  destination register (R-type) or immediate (I-type).
- j_addr  in  12  jump target.
- flush  in  1  synchronous clear.
- imem_we  out  1  write request to instruction memory.
- imem_ready  in  1  memory accepts the write.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  16  encoded instruction.
- count  out  $clog2(FIFO_DEPTH)+1  buffered words.
- err  out  1  sticky illegal-bundle flag.

Function
REQ-005 A bundle SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-006 in_ready SHALL be 1 iff count<FIFO_DEPTH, state!=ERR and flush=0; a pop in the same cycle SHALL NOT raise in_ready when full.
REQ-007 The opcode SHALL be 4'b0101 when ctl_jump=1, otherwise ctl_aluop.
REQ-008 Legal opcodes SHALL be 0000 ADD, 0001 SUB, 0110 XOR, 0111 OR (R-type), 0010 ADDI, 0011 LW, 0100 SW (I-type) and 0101 J.
REQ-009 R-type words SHALL be encoded as {op,f_rs,f_rt,f_rd}, I-type as {op,f_rs,f_rt,f_rd-as-imm}, and J as {0101,j_addr}.
REQ-010 Encoding SHALL be registered at push, so the earliest imem_we assertion is the cycle after acceptance.
REQ-011 The FSM SHALL have states IDLE (empty), WRITE (count>0, imem_we=1) and ERR.
- IDLE->WRITE on push.
- WRITE->IDLE when the last word pops with no push.
- Any state->ERR on an illegal accepted bundle.
- ERR->IDLE only on flush.
REQ-012 A write SHALL complete on imem_we&&imem_ready; the FIFO pops and imem_addr increments by 1.
REQ-013 imem_addr SHALL wrap from 2^ADDR_W-1 to 0 with no stall.
REQ-014 imem_wdata and imem_addr SHALL be stable while imem_we=1 and imem_ready=0.
REQ-015 A simultaneous push and pop with 0<count<FIFO_DEPTH SHALL leave count unchanged and preserve FIFO order.
REQ-016 flush SHALL empty the FIFO, zero imem_addr, clear err and enter IDLE on the next edge, overriding a same-cycle push or pop.
REQ-017 In ERR, already-buffered legal words SHALL continue draining to memory.

Reset
REQ-018 rst_n=0 SHALL immediately force state=IDLE, count=0, imem_we=0, imem_addr=0, imem_wdata=0, err=0 and in_ready=0.
REQ-019 in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-020 Reset mid-write SHALL discard all buffered words.

Configuration
REQ-021 With INSTR_ENC_CHECK_EN defined, an accepted bundle SHALL be illegal if:
- the opcode is not in REQ-008, or
- any ctl_* bit differs from the decode table for that opcode (e.g. ADDI requires alusrc=1, regwrite=1, all others 0).
An illegal bundle SHALL set err, SHALL NOT be pushed, and SHALL enter ERR.
REQ-022 Without INSTR_ENC_CHECK_EN:
- only ctl_jump and ctl_aluop SHALL be used;
- every bundle SHALL be encoded and pushed;
- err SHALL be tied 0;
- ERR SHALL be unreachable.

Structure
REQ-023 The opcode localparams, the instruction-type enum and the per-opcode expected control-bit table SHALL live in the shared package mips_isa_pkg.
REQ-024 The FIFO SHALL be the single sub-module sync_fifo (parameterised width and depth, push/pop/full/empty/count).

Verification
REQ-025 Reset, then push ADD rs=1 rt=2 rd=3 with ctl_regdst=1, ctl_regwrite=1 -> next cycle imem_we=1, imem_wdata=16'h0123, imem_addr=0.
REQ-026 Push J j_addr=12'hABC with imem_ready=0 for 3 cycles -> imem_wdata=16'h5ABC held stable; it pops on the 4th cycle and imem_addr=1.
REQ-027 With imem_ready=0, push 4 bundles -> count=4 and in_ready=0; a 5th in_valid is not accepted; raise imem_ready -> words written in order at addresses 0..3.
REQ-028 Start imem_addr at 255 (ADDR_W=8) and write 2 words -> addresses 255 then 0.
REQ-029 With INSTR_ENC_CHECK_EN, push ADDI with ctl_memread=1 -> err=1, state ERR, in_ready=0, word not written; flush -> err=0 and in_ready=1.
REQ-030 Assert rst_n=0 with 2 words buffered -> imem_we drops immediately and count=0.
